matmul_uart_ctrl: RTL and testbench
===================================

Name: matmul_uart_ctrl

Overview:
Command sequencer between the UART byte interfaces and the matrix-multiply datapath. It waits for a sync byte, then loads N×N operand matrices A and B from the UART receiver into the operand memories. It then starts the multiplier and streams every result element back through the UART transmitter, MSB byte first. It is the only master of the operand-memory write ports and the result-memory read port.

Parameters:
N, 2, matrix dimension; N*N elements per matrix.
DW, 8, operand element width in bits; one element per received byte.
RW, 2*DW+$clog2(N) (17 at defaults), result element width.
RB, (RW+7)/8 (3 at defaults), bytes transmitted per result element.
TIMEOUT, 1000000, maximum idle cycles between received bytes during load (about 10 ms at 100 MHz).
SYNC, 8'hA5, command sync byte.

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to UART transmitter
tx_start  out  1  one-cycle strobe, launches tx_data
tx_busy  in  1  transmitter busy
mem_wdata  out  DW  operand write data
a_we  out  1  write strobe, matrix A memory
b_we  out  1  write strobe, matrix B memory
mem_addr  out  $clog2(N*N)  shared operand write address / result read address, row-major
mm_start  out  1  one-cycle multiplier start
mm_done  in  1  one-cycle multiplier completion
res_data  in  RW  result memory read data; synchronous read, 1-cycle latency
busy  out  1  high in every state except IDLE
err  out  1  sticky load-timeout flag

Behaviour:
- Reset (async): state IDLE; all outputs 0. Applying reset in any state aborts the operation immediately; memory contents are not cleared.
- IDLE: on rx_valid with rx_data==SYNC, clear err and idx, then go to LOAD_A. Other bytes are ignored.
- LOAD_A: on each rx_valid, drive a_we=1 for one cycle with mem_addr=idx and mem_wdata=rx_data[DW-1:0], then increment idx. After element N*N-1, reset idx to 0 and go to LOAD_B.
- LOAD_B: same as LOAD_A using b_we. After the last element, pulse mm_start for one cycle and go to COMPUTE.
- Load timeout: the gap counter resets on every rx_valid and on entry to LOAD_A. If it reaches TIMEOUT while in LOAD_A or LOAD_B, set err=1 and return to IDLE. The next SYNC byte restarts the load from element 0.
- COMPUTE: wait for mm_done. Then idx=0 and go to FETCH. mm_done seen in any other state is ignored.
- FETCH: drive mem_addr=idx. After 1 cycle, capture res_data into a shift register zero-extended to RB*8 bits, set the byte counter to RB, and go to SEND.
- SEND: when tx_busy==0, drive tx_data = top byte of the shift register, pulse tx_start, shift left by 8, and go to TX_WAIT.
- TX_WAIT: ignore tx_busy on the first cycle; this guards the transmitter's 1-cycle busy assertion latency. After that, wait for tx_busy==0.
  - Bytes remain for this element: go to SEND.
  - Element done and idx<N*N-1: increment idx and go to FETCH.
  - Last element done: go to IDLE.
- rx_valid in COMPUTE, FETCH, SEND or TX_WAIT is dropped, including SYNC; no queueing.
- Counter widths: idx is $clog2(N*N) bits, or 1 bit minimum when N*N=1. The gap counter is $clog2(TIMEOUT+1) bits and saturates.
- Throughput: back-to-back rx_valid strobes on consecutive cycles are all accepted. Each write is committed in the same cycle as its strobe.

Decomposition:
- Package matmul_pkg: SYNC_BYTE constant, state enum (IDLE, LOAD_A, LOAD_B, COMPUTE, FETCH, SEND, TX_WAIT), and a clog2 helper function.
- One sub-module, rx_gap_timer: loadable saturating counter with clear input and expire output; parameter TIMEOUT.

Test Plan:
- Full command, N=2: A5, A = 01 02 03 04, B = 05 06 07 08, then mm_done → A/B memory writes match row-major order. TX bytes are 00 00 13, 00 00 16, 00 00 2B, 00 00 32. busy returns to 0 afterwards.
- Garbage before sync: 00 FF 5A, then A5 plus a valid load → no memory writes until after A5; result stream unchanged from the first test.
- TIMEOUT=50 override, A5 01 02 then silence → err=1 at gap cycle 50, state IDLE. A following A5 clears err and A is rewritten from address 0.
- Slow transmitter: hold tx_busy high for 20 cycles after each tx_start → exactly 12 tx_start pulses in total, none while tx_busy=1.
- Reset asserted mid-SEND (after 5th byte) → tx_start, busy and err read 0 immediately. A new full command then produces the complete 12-byte stream.
- Max operands: all elements FF → each result 0x1FC02, sent as 01 FC 02.

Source files
------------

// File: rtl/matmul_pkg.sv
// ----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-multiply UART command sequencer:
//   SYNC_BYTE - command sync byte that starts an operand load
//   state_t   - sequencer states
//   clog2     - ceil(log2(value)), never less than 1, for sizing counters that
//               must stay at least one bit wide
// ----------------------------------------------------------------------------
package matmul_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        FETCH,
        SEND,
        TX_WAIT
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// ----------------------------------------------------------------------------
// rx_gap_timer
// Counts idle cycles between received bytes. The count returns to zero
// whenever clr is high and otherwise climbs by one per cycle, saturating at
// TIMEOUT so a long silence cannot wrap back to a harmless value.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   clr    in  zero the count this cycle
//   expire out count has reached TIMEOUT
// ----------------------------------------------------------------------------
module rx_gap_timer
    import matmul_pkg::*;
#(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expire
);

    localparam int CW = clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // NOTE: registers are written only with non-blocking assignments so every
    // always_ff reads the pre-edge value of its neighbours, with no race.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != CW'(TIMEOUT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == CW'(TIMEOUT));

endmodule

// File: rtl/matmul_uart_ctrl.sv
// ----------------------------------------------------------------------------
// matmul_uart_ctrl
// Command sequencer between the UART byte interfaces and the matrix-multiply
// datapath. After a SYNC byte it loads N*N elements of A, then N*N of B, into
// the operand memories, starts the multiplier, and streams every result
// element back out through the transmitter, MSB byte first.
//   clk, rst           clock, asynchronous active-high reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   tx_data, tx_start  byte to transmit and its one-cycle launch strobe
//   tx_busy            transmitter busy
//   mem_wdata          operand write data
//   a_we, b_we         operand memory write strobes
//   mem_addr           operand write / result read address, row-major
//   mm_start, mm_done  multiplier start / completion strobes
//   res_data           result memory read data, one cycle after mem_addr
//   busy               high in every state except IDLE
//   err                sticky load-timeout flag, cleared by the next SYNC
// ----------------------------------------------------------------------------
module matmul_uart_ctrl
    import matmul_pkg::*;
#(
    parameter int         N       = 2,
    parameter int         DW      = 8,
    parameter int         RW      = 2 * DW + $clog2(N),
    parameter int         RB      = (RW + 7) / 8,
    parameter int         TIMEOUT = 1000000,
    parameter logic [7:0] SYNC    = SYNC_BYTE,
    localparam int        AW      = clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic [DW-1:0] mem_wdata,
    output logic          a_we,
    output logic          b_we,
    output logic [AW-1:0] mem_addr,
    output logic          mm_start,
    input  logic          mm_done,
    input  logic [RW-1:0] res_data,
    output logic          busy,
    output logic          err
);

    localparam int            SW   = RB * 8;
    localparam int            BW   = clog2(RB + 1);
    localparam logic [AW-1:0] LAST = AW'(N * N - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [SW-1:0] shreg;
    logic [BW-1:0] byte_cnt;
    logic          fetch_ph;   // 0: address presented, 1: res_data valid
    logic          tx_first;   // first TX_WAIT cycle, tx_busy not yet valid
    logic          loading;
    logic          gap_expire;

    assign loading = (state == LOAD_A) || (state == LOAD_B);

    // Operand writes follow the receive strobe in the same cycle, so
    // back-to-back bytes each land without any buffering.
    assign a_we      = (state == LOAD_A) && rx_valid;
    assign b_we      = (state == LOAD_B) && rx_valid;
    assign mem_wdata = loading ? rx_data[DW-1:0] : '0;
    assign mem_addr  = idx;
    assign busy      = (state != IDLE);

    // Held clear outside the load states, so entering LOAD_A starts from zero.
    rx_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (rx_valid || !loading),
        .expire (gap_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            shreg    <= '0;
            byte_cnt <= '0;
            fetch_ph <= 1'b0;
            tx_first <= 1'b0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            mm_start <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            mm_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC) begin
                        err   <= 1'b0;
                        idx   <= '0;
                        state <= LOAD_A;
                    end
                end

                LOAD_A, LOAD_B: begin
                    // A byte arriving on the expiry cycle is still accepted.
                    if (rx_valid) begin
                        if (idx == LAST) begin
                            idx <= '0;
                            if (state == LOAD_A) begin
                                state <= LOAD_B;
                            end else begin
                                mm_start <= 1'b1;
                                state    <= COMPUTE;
                            end
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else if (gap_expire) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end

                COMPUTE: begin
                    if (mm_done) begin
                        idx      <= '0;
                        fetch_ph <= 1'b0;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        shreg    <= SW'(res_data);
                        byte_cnt <= BW'(RB);
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= shreg[SW-1 -: 8];
                        tx_start <= 1'b1;
                        shreg    <= shreg << 8;
                        byte_cnt <= byte_cnt - BW'(1);
                        tx_first <= 1'b1;
                        state    <= TX_WAIT;
                    end
                end

                TX_WAIT: begin
                    if (tx_first) begin
                        tx_first <= 1'b0;
                    end else if (!tx_busy) begin
                        if (byte_cnt != '0) begin
                            state <= SEND;
                        end else if (idx != LAST) begin
                            idx      <= idx + AW'(1);
                            fetch_ph <= 1'b0;
                            state    <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_uart_ctrl.sv
// ----------------------------------------------------------------------------
// tb_matmul_uart_ctrl
// Directed bench for matmul_uart_ctrl at N=2, DW=8 with a short load timeout.
// Around the DUT sit an operand memory, a multiplier with a registered result
// memory, and a transmitter whose busy rises one cycle after tx_start.
// ----------------------------------------------------------------------------
module tb_matmul_uart_ctrl;

    localparam logic [95:0] STREAM_BASIC = 96'h000013_000016_00002B_000032;
    localparam logic [95:0] STREAM_MAX   = 96'h01FC02_01FC02_01FC02_01FC02;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  mem_wdata;
    logic        a_we;
    logic        b_we;
    logic [1:0]  mem_addr;
    logic        mm_start;
    logic        mm_done;
    logic [16:0] res_data;
    logic        busy;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    matmul_uart_ctrl #(
        .N       (2),
        .DW      (8),
        .TIMEOUT (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_wdata (mem_wdata),
        .a_we      (a_we),
        .b_we      (b_we),
        .mem_addr  (mem_addr),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .res_data  (res_data),
        .busy      (busy),
        .err       (err)
    );

    // ---------------- environment models ----------------
    typedef struct {
        int is_b;
        int addr;
        int data;
    } wr_t;

    logic [7:0]  a_mem [4];
    logic [7:0]  b_mem [4];
    logic [16:0] c_mem [4];
    wr_t         wr_q [$];
    logic [7:0]  tx_q [$];
    int          tx_viol  = 0;
    int          busy_len = 2;
    int          busy_cnt = 0;

    always @(posedge clk) begin
        if (a_we) begin
            a_mem[mem_addr] <= mem_wdata;
            wr_q.push_back('{0, int'(mem_addr), int'(mem_wdata)});
        end
        if (b_we) begin
            b_mem[mem_addr] <= mem_wdata;
            wr_q.push_back('{1, int'(mem_addr), int'(mem_wdata)});
        end
        res_data <= c_mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mm_start) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    c_mem[i*2+j] = 17'(a_mem[i*2] * b_mem[j]) + 17'(a_mem[i*2+1] * b_mem[2+j]);
                end
            end
            repeat (3) @(negedge clk);
            mm_done = 1'b1;
            @(negedge clk);
            mm_done = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (tx_busy) tx_viol++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SYNC, then A and B elements, all on consecutive cycles.
    task automatic run_cmd(input logic [31:0] a, input logic [31:0] b);
        wr_q.delete();
        tx_q.delete();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = a[31-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_data = b[31-8*i -: 8];
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        check({tag, "_wr_count"}, wr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            exp = {15'd0, (i >= 4), 6'd0, 2'(i % 4),
                   (i < 4) ? a[31-8*i -: 8] : b[31-8*(i-4) -: 8]};
            check({tag, "_wr"}, {15'd0, wr_q[i].is_b[0], 8'(wr_q[i].addr), 8'(wr_q[i].data)}, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int c = 0; c < budget && busy; c++) @(negedge clk);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    task automatic check_stream(input string tag, input logic [95:0] exp);
        check({tag, "_tx_count"}, tx_q.size(), 12);
        for (int i = 0; i < 12 && i < tx_q.size(); i++) begin
            check({tag, "_tx_byte"}, tx_q[i], exp[95-8*i -: 8]);
        end
        check({tag, "_tx_while_busy"}, tx_viol, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        mm_done  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data",  tx_data,  0);
        check("rst_busy",     busy,     0);
        check("rst_err",      err,      0);
        check("rst_a_we",     a_we,     0);
        check("rst_b_we",     b_we,     0);
        check("rst_mm_start", mm_start, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full command with small operands.
        run_cmd(32'h01020304, 32'h05060708);
        check_writes("basic", 32'h01020304, 32'h05060708);
        wait_done("basic", 500);
        check_stream("basic", STREAM_BASIC);

        // Garbage bytes before the sync byte are ignored.
        wr_q.delete();
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h00;
        @(negedge clk); rx_data = 8'hFF;
        @(negedge clk); rx_data = 8'h5A;
        @(negedge clk); rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("garbage_no_writes", wr_q.size(), 0);
        check("garbage_idle", busy, 0);
        run_cmd(32'h01020304, 32'h05060708);
        check_writes("garbage", 32'h01020304, 32'h05060708);
        wait_done("garbage", 500);
        check_stream("garbage", STREAM_BASIC);

        // Load timeout after two A elements, then recovery.
        wr_q.delete();
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'hA5;
        @(negedge clk); rx_data = 8'h01;
        @(negedge clk); rx_data = 8'h02;
        @(negedge clk); rx_valid = 1'b0;
        repeat (49) @(negedge clk);
        check("timeout_err_early", err, 0);
        check("timeout_busy_early", busy, 1);
        repeat (3) @(negedge clk);
        check("timeout_err", err, 1);
        check("timeout_idle", busy, 0);
        check("timeout_partial_writes", wr_q.size(), 2);
        run_cmd(32'h01020304, 32'h05060708);
        check("timeout_err_cleared", err, 0);
        check_writes("reload", 32'h01020304, 32'h05060708);
        wait_done("reload", 500);
        check_stream("reload", STREAM_BASIC);

        // Slow transmitter.
        busy_len = 20;
        run_cmd(32'h01020304, 32'h05060708);
        wait_done("slow", 2000);
        check_stream("slow", STREAM_BASIC);

        // Reset while streaming, right after the fifth byte launches.
        run_cmd(32'h01020304, 32'h05060708);
        for (int c = 0; c < 2000 && tx_q.size() < 5; c++) @(negedge clk);
        check("abort_reached_5th", tx_q.size(), 5);
        #2 rst = 1'b1;
        #1;
        check("abort_tx_start", tx_start, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(32'h01020304, 32'h05060708);
        wait_done("after_abort", 2000);
        check_stream("after_abort", STREAM_BASIC);

        // Largest operands.
        busy_len = 2;
        run_cmd(32'hFFFFFFFF, 32'hFFFFFFFF);
        check_writes("max", 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("max", 500);
        check_stream("max", STREAM_MAX);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
